// File: rtl/reg_file_2r1w.sv
// Two-read/one-write register file with a post-reset clearing sequencer and write-first bypass.
// Optional build macro REGFILE_ZERO_REG_EN hard-wires entry 0 to zero.
module reg_file_2r1w #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DEPTH  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic [ADDR_W-1:0] rd_addr_a_i,
    output logic [DATA_W-1:0] rd_data_a_o,
    input  logic [ADDR_W-1:0] rd_addr_b_i,
    output logic [DATA_W-1:0] rd_data_b_o,
    output logic              busy_o,
    output logic              wr_drop_o
);

    typedef enum logic [0:0] {StInit, StReady} state_e;

    localparam logic [ADDR_W-1:0] LastPtr = ADDR_W'(DEPTH - 1);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   init_ptr_q, init_ptr_d;
    logic                busy_q, busy_d;
    logic                wr_drop_q, wr_drop_d;
    logic [DATA_W-1:0]   rd_a_q, rd_a_d;
    logic [DATA_W-1:0]   rd_b_q, rd_b_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];

    logic                mem_we;
    logic [ADDR_W-1:0]   mem_waddr;
    logic [DATA_W-1:0]   mem_wdata;
    logic                wr_ok;
    logic [DATA_W-1:0]   rd_val_a, rd_val_b;

`ifdef REGFILE_ZERO_REG_EN
    // Entry 0 is constant zero: writes to it vanish and it never bypasses.
    assign wr_ok    = wr_en_i && (wr_addr_i != '0);
    assign rd_val_a = (rd_addr_a_i == '0) ? '0 : mem_q[rd_addr_a_i];
    assign rd_val_b = (rd_addr_b_i == '0) ? '0 : mem_q[rd_addr_b_i];
`else
    assign wr_ok    = wr_en_i;
    assign rd_val_a = mem_q[rd_addr_a_i];
    assign rd_val_b = mem_q[rd_addr_b_i];
`endif

    always_comb begin
        state_d    = state_q;
        init_ptr_d = init_ptr_q;
        busy_d     = busy_q;
        wr_drop_d  = 1'b0;
        rd_a_d     = rd_a_q;
        rd_b_d     = rd_b_q;
        mem_we     = 1'b0;
        mem_waddr  = wr_addr_i;
        mem_wdata  = wr_data_i;
        unique case (state_q)
            StInit: begin
                mem_we     = 1'b1;
                mem_waddr  = init_ptr_q;
                mem_wdata  = '0;
                init_ptr_d = init_ptr_q + ADDR_W'(1);
                rd_a_d     = '0;
                rd_b_d     = '0;
                wr_drop_d  = wr_en_i;
                if (init_ptr_q == LastPtr) begin
                    state_d = StReady;
                    busy_d  = 1'b0;
                end
            end
            StReady: begin
                mem_we = wr_ok;
                rd_a_d = (wr_ok && (rd_addr_a_i == wr_addr_i)) ? wr_data_i : rd_val_a;
                rd_b_d = (wr_ok && (rd_addr_b_i == wr_addr_i)) ? wr_data_i : rd_val_b;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= StInit;
            init_ptr_q <= '0;
            busy_q     <= 1'b1;
            wr_drop_q  <= 1'b0;
            rd_a_q     <= '0;
            rd_b_q     <= '0;
        end else begin
            state_q    <= state_d;
            init_ptr_q <= init_ptr_d;
            busy_q     <= busy_d;
            wr_drop_q  <= wr_drop_d;
            rd_a_q     <= rd_a_d;
            rd_b_q     <= rd_b_d;
        end
    end

    // Storage has no reset; the init sequencer clears it after every reset.
    always_ff @(posedge clk_i) begin
        if (!rst_i && mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    assign rd_data_a_o = rd_a_q;
    assign rd_data_b_o = rd_b_q;
    assign busy_o      = busy_q;
    assign wr_drop_o   = wr_drop_q;

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Directed self-checking bench for reg_file_2r1w; expected values are hand-computed constants.
module tb_reg_file_2r1w;

    localparam int unsigned DW = 8;
    localparam int unsigned AW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic [AW-1:0] rd_addr_a = '0;
    logic [AW-1:0] rd_addr_b = '0;
    logic [DW-1:0] rd_data_a;
    logic [DW-1:0] rd_data_b;
    logic          busy;
    logic          wr_drop;

    int total = 0;
    int bad   = 0;
    int n;

    always #5 clk = ~clk;

    reg_file_2r1w #(
        .DATA_W(DW),
        .ADDR_W(AW),
        .DEPTH (16)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .wr_en_i    (wr_en),
        .wr_addr_i  (wr_addr),
        .wr_data_i  (wr_data),
        .rd_addr_a_i(rd_addr_a),
        .rd_data_a_o(rd_data_a),
        .rd_addr_b_i(rd_addr_b),
        .rd_data_b_o(rd_data_b),
        .busy_o     (busy),
        .wr_drop_o  (wr_drop)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Counts cycles until busy drops, bounded so a stuck sequencer cannot hang the run.
    task automatic wait_busy(output int cnt);
        cnt = 0;
        while (busy === 1'b1 && cnt < 40) begin
            tick();
            cnt++;
        end
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    initial begin
        // 1: reset and init sequencer
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("rst_busy", busy, 1);
        check("rst_rd_a", rd_data_a, 0);
        check("rst_rd_b", rd_data_b, 0);
        check("rst_wr_drop", wr_drop, 0);
        wait_busy(n);
        check("init_len", n, 16);
        for (int i = 0; i < 16; i++) begin
            rd_addr_a = AW'(i);
            rd_addr_b = AW'(15 - i);
            tick();
            check("init_clear_a", rd_data_a, 0);
            check("init_clear_b", rd_data_b, 0);
        end

        // 2: write then read on both ports
        rd_addr_a = 4'd0;
        rd_addr_b = 4'd0;
        wr(4'd3, 8'h5A);
        check("ready_wr_drop", wr_drop, 0);
        wr(4'd15, 8'hC3);
        rd_addr_a = 4'd3;
        rd_addr_b = 4'd15;
        tick();
        check("rd_a_3", rd_data_a, 8'h5A);
        check("rd_b_15", rd_data_b, 8'hC3);

        // 3: write-first bypass on both ports
        wr(4'd7, 8'h11);
        rd_addr_a = 4'd7;
        rd_addr_b = 4'd7;
        tick();
        check("pre_bypass_a", rd_data_a, 8'h11);
        wr(4'd7, 8'h99);
        check("bypass_a", rd_data_a, 8'h99);
        check("bypass_b", rd_data_b, 8'h99);
        tick();
        check("after_bypass_a", rd_data_a, 8'h99);
        // bypass on one port only
        rd_addr_a = 4'd3;
        rd_addr_b = 4'd8;
        wr(4'd8, 8'h42);
        check("bypass_b_only", rd_data_b, 8'h42);
        check("no_bypass_a", rd_data_a, 8'h5A);

        // held wr_en: last value wins
        wr_en   = 1'b1;
        wr_addr = 4'd5;
        wr_data = 8'h12;
        tick();
        wr_data = 8'h34;
        tick();
        wr_en     = 1'b0;
        rd_addr_a = 4'd5;
        tick();
        check("last_wins", rd_data_a, 8'h34);

        // 4: write during init is dropped and flagged
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("init_rd_zero", rd_data_a, 0);
        wr(4'd2, 8'hFF);
        check("drop_pulse", wr_drop, 1);
        tick();
        check("drop_clear", wr_drop, 0);
        wait_busy(n);
        check("init_remaining", n, 10);
        rd_addr_a = 4'd2;
        tick();
        check("dropped_addr2", rd_data_a, 0);

        // 5: reset mid-init restarts the full clear
        wr(4'd9, 8'hAA);
        rd_addr_b = 4'd9;
        tick();
        check("fill_9", rd_data_b, 8'hAA);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        check("mid_init_busy", busy, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        wait_busy(n);
        check("reinit_len", n, 16);
        tick();
        check("reinit_addr9", rd_data_b, 0);

        // 6: address 0 behaviour depends on the zero-register build
        rd_addr_a = 4'd0;
        wr(4'd0, 8'h77);
`ifdef REGFILE_ZERO_REG_EN
        check("zero_bypass", rd_data_a, 0);
`else
        check("zero_bypass", rd_data_a, 8'h77);
`endif
        check("zero_wr_drop", wr_drop, 0);
        tick();
`ifdef REGFILE_ZERO_REG_EN
        check("zero_reg", rd_data_a, 0);
`else
        check("zero_reg", rd_data_a, 8'h77);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
